dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Two-port arbiter/sequencer in front of the single-port Data_Memory. Port 0 serves the
//   pipeline MEM stage, port 1 a secondary master (debug/DMA). Grants one request at a time
//   by round-robin, latches it and holds the memory strobes for LATENCY cycles. Returns
//   read data and a one-cycle ack; busy_o lets the hazard unit stall the pipeline.
// PARAMETERS
//   LATENCY  3   cycles mem strobes are held per access; legal range 1..15
// PORTS
//   clk_i        in   1   clock, rising edge
//   rst_i        in   1   asynchronous, active-low reset
//   m0_req_i     in   1   port 0 request; held high until m0_ack_o
//   m0_we_i      in   1   port 0: 1 = write, 0 = read
//   m0_addr_i    in   32  port 0 address
//   m0_wdata_i   in   32  port 0 write data
//   m0_ack_o     out  1   port 0 completion pulse
//   m0_rdata_o   out  32  port 0 read data, valid from ack cycle on
//   m1_*         --   --  port 1: same six signals, same widths and meaning
//   mem_addr_o   out  32  to Data_Memory address_i
//   mem_wdata_o  out  32  to Data_Memory write_data_i
//   mem_read_o   out  1   to Data_Memory MemRead_i
//   mem_write_o  out  1   to Data_Memory MemWrite_i
//   mem_rdata_i  in   32  from Data_Memory read_data_o
//   busy_o       out  1   1 whenever FSM is not IDLE
// BEHAVIOUR
//   Reset (rst_i low, async): state=IDLE, cnt=0, last_grant=1, all outputs 0,
//     m0/m1_rdata_o=0, latched addr/wdata/we=0.
//   FSM: IDLE -> ACCESS when any req high at the edge; ACCESS -> DONE when cnt==LATENCY-1;
//     DONE -> IDLE always. No other transitions.
//   Grant (IDLE only): one req high -> that port; both high -> port != last_grant.
//     last_grant updated on the IDLE->ACCESS edge. First tie after reset goes to port 0.
//   On IDLE->ACCESS edge, latch granted port's addr, wdata, we, port id. Requester
//     changes during ACCESS/DONE are ignored.
//   ACCESS: mem_addr_o/mem_wdata_o = latched values; mem_write_o = we; mem_read_o = ~we;
//     cnt increments each cycle, cleared on leaving ACCESS. Outside ACCESS: all mem_* = 0.
//   Last ACCESS cycle (cnt==LATENCY-1), read: mem_rdata_i captured into granted port's rdata
//     register at the edge. Writes leave both rdata registers unchanged.
//   DONE: granted port's ack_o high for exactly this cycle; the other ack stays 0.
//   Latency: req sampled at edge E -> ACCESS for LATENCY cycles -> ack in cycle LATENCY+1
//     after E. Minimum per-access occupancy is LATENCY+2 cycles (incl. IDLE).
//   Requester drops req at the edge where it sees ack. A req still high in IDLE is a
//     new request.
//   Ungranted port keeps waiting with req high. Round-robin prevents starvation:
//     worst-case wait is one other access.
//   Address is passed through unmodified; no alignment check.
//   Reset mid-ACCESS aborts: no ack. Memory content at the latched address is undefined
//     for an aborted write.
//   busy_o = (state != IDLE); combinational from state register.
// TESTING
//   1 LATENCY=3, mem[8]=0xDEADBEEF; m0 read addr 8 at E0 -> mem_read_o=1 cycles 1..3,
//     mem_addr_o=8, m0_ack_o pulse cycle 4, m0_rdata_o=0xDEADBEEF, m1_ack_o=0.
//   2 m1 write addr 4 data 0x12345678, then m1 read addr 4 -> mem_write_o=1 for 3 cycles
//     only in the first access; second ack returns 0x12345678; m0_rdata_o stays 0.
//   3 After reset, m0 and m1 both hold req continuously (each re-requests after its ack)
//     -> grants 0,1,0,1; each ack 5 cycles apart.
//   4 During ACCESS change m0_addr_i 8->12 and m0_wdata_i -> mem_addr_o stays 8,
//     mem_wdata_o unchanged.
//   5 rst_i low during 2nd ACCESS cycle -> all outputs 0 immediately; after release:
//     IDLE, busy_o=0, no ack.
//   6 LATENCY=1: m0 read -> one-cycle mem_read_o, ack 2 cycles after the sampling edge.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory masters, the arbiter and Data_Memory.
// The arbiter takes the slave view; requesters and memory model take the master view.
interface dmem_arbiter_if;
    logic        m0_req_i;
    logic        m0_we_i;
    logic [31:0] m0_addr_i;
    logic [31:0] m0_wdata_i;
    logic        m0_ack_o;
    logic [31:0] m0_rdata_o;

    logic        m1_req_i;
    logic        m1_we_i;
    logic [31:0] m1_addr_i;
    logic [31:0] m1_wdata_i;
    logic        m1_ack_o;
    logic [31:0] m1_rdata_o;

    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_rdata_i;
    logic        busy_o;

    modport slave (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
        output m0_ack_o, m0_rdata_o,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
        output m1_ack_o, m1_rdata_o,
        output mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o,
        input  mem_rdata_i,
        output busy_o
    );

    modport master (
        output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
        input  m0_ack_o, m0_rdata_o,
        output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
        input  m1_ack_o, m1_rdata_o,
        input  mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o,
        output mem_rdata_i,
        input  busy_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of the single-port data memory.
// One access at a time: IDLE -> ACCESS (LATENCY cycles) -> DONE (ack) -> IDLE.
module dmem_arbiter #(
    parameter int unsigned LATENCY = 3
) (
    input logic           clk_i,
    input logic           rst_i,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] LAST = 4'(LATENCY - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        last_grant;
    logic        gnt;
    logic        pick;
    logic        any_req;
    logic        last_cyc;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] rdata0;
    logic [31:0] rdata1;

    assign any_req  = bus.m0_req_i | bus.m1_req_i;
    // on a tie the port that did not win last time goes next
    assign pick     = (bus.m0_req_i & bus.m1_req_i) ? ~last_grant
                                                    : bus.m1_req_i;
    assign last_cyc = (state == ACCESS) && (cnt == LAST);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        bus.mem_read_o  = 1'b0;
        bus.mem_write_o = 1'b0;
        bus.m0_ack_o    = 1'b0;
        bus.m1_ack_o    = 1'b0;
        bus.busy_o      = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (any_req) state_nxt = ACCESS;
            end
            ACCESS: begin
                bus.mem_addr_o  = lat_addr;
                bus.mem_wdata_o = lat_wdata;
                bus.mem_write_o = lat_we;
                bus.mem_read_o  = ~lat_we;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                bus.m0_ack_o = ~gnt;
                bus.m1_ack_o = gnt;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt        <= '0;
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            if (state == ACCESS && !last_cyc) begin
                cnt <= cnt + 4'd1;
            end else begin
                cnt <= '0;
            end
            if (state == IDLE && any_req) begin
                gnt        <= pick;
                last_grant <= pick;
                lat_we     <= pick ? bus.m1_we_i : bus.m0_we_i;
                lat_addr   <= pick ? bus.m1_addr_i : bus.m0_addr_i;
                lat_wdata  <= pick ? bus.m1_wdata_i : bus.m0_wdata_i;
            end
            if (last_cyc && !lat_we) begin
                if (gnt) begin
                    rdata1 <= bus.mem_rdata_i;
                end else begin
                    rdata0 <= bus.mem_rdata_i;
                end
            end
        end
    end

    assign bus.m0_rdata_o = rdata0;
    assign bus.m1_rdata_o = rdata1;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed timing cases, then random two-master
// traffic scored against a per-port reference memory.
module tb_dmem_arbiter;
    localparam int LAT   = 3;
    localparam int BOUND = 2 * LAT + 4;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          icyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_clr = 1'b1;
    logic mon_en = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    dmem_arbiter_if b ();
    dmem_arbiter_if b1 ();

    dmem_arbiter #(.LATENCY(LAT)) u_dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (b)
    );

    dmem_arbiter #(.LATENCY(1)) u_dut1 (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (b1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        if (i == 2) return 32'hDEADBEEF;
        return 32'hA5A50000 | 32'(i * 257);
    endfunction

    // Data_Memory stand-in: combinational read, clocked write
    logic [31:0] dmem [0:63];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) dmem[i] <= init_word(i);
        end else if (b.mem_write_o) begin
            dmem[b.mem_addr_o[7:2]] <= b.mem_wdata_o;
        end
    end
    assign b.mem_rdata_i  = dmem[b.mem_addr_o[7:2]];
    assign b1.mem_rdata_i = 32'hCAFEF00D;

    logic [31:0] ref_mem [0:63];
    logic [31:0] last_rd [0:1];
    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act,
                         input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic req, input logic we,
                            input logic [31:0] addr,
                            input logic [31:0] wdata);
        if (p == 0) begin
            b.m0_req_i   = req;
            b.m0_we_i    = we;
            b.m0_addr_i  = addr;
            b.m0_wdata_i = wdata;
        end else begin
            b.m1_req_i   = req;
            b.m1_we_i    = we;
            b.m1_addr_i  = addr;
            b.m1_wdata_i = wdata;
        end
    endtask

    task automatic set_req(input int p, input logic v);
        if (p == 0) b.m0_req_i = v;
        else        b.m1_req_i = v;
    endtask

    function automatic logic get_ack(input int p);
        return (p == 0) ? b.m0_ack_o : b.m1_ack_o;
    endfunction

    function automatic logic [31:0] get_rd(input int p);
        return (p == 0) ? b.m0_rdata_o : b.m1_rdata_o;
    endfunction

    task automatic do_reset();
        rst_n   = 1'b0;
        mem_clr = 1'b1;
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        repeat (2) tick();
        mem_clr = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic xfer(input int p, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output int nwr,
                        output int nrd, output int lat);
        bit got;
        got = 0;
        nwr = 0;
        nrd = 0;
        lat = 0;
        rd  = '0;
        set_port(p, 1'b1, we, addr, wdata);
        for (int i = 1; i <= 40 && !got; i++) begin
            tick();
            if (b.mem_write_o) nwr++;
            if (b.mem_read_o) nrd++;
            if (get_ack(p)) begin
                got = 1;
                lat = i;
                rd  = get_rd(p);
            end
        end
        set_req(p, 1'b0);
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: port %0d got no ack required one", p);
        end
        tick();
    endtask

    task automatic issue(input int p);
        exp_t e;
        int   w;
        w       = p * 32 + int'($urandom_range(0, 31));
        e.we    = 1'($urandom_range(0, 1));
        e.addr  = 32'(w * 4);
        e.wdata = $urandom;
        if (e.we) begin
            ref_mem[w] = e.wdata;
            e.rd = last_rd[p];
        end else begin
            e.rd = ref_mem[w];
        end
        last_rd[p] = e.rd;
        e.icyc = cyc;
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
        set_port(p, 1'b1, e.we, e.addr, e.wdata);
    endtask

    // scoreboard monitor: follows the memory strobes and scores every ack
    int          scnt = 0;
    logic [31:0] s_addr;
    logic [31:0] s_wd;
    logic        s_we;

    task automatic mon_port(input int p);
        exp_t e;
        if (get_ack(p)) begin
            if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: port %0d acked with no request", p);
            end else begin
                e = (p == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("rdata_p%0d", p), get_rd(p), e.rd);
                chk("strobe_cycles", 32'(scnt), 32'(LAT));
                chk("mem_addr", s_addr, e.addr);
                chk_b("mem_we", s_we, e.we);
                if (e.we) chk("mem_wdata", s_wd, e.wdata);
                chk_b("wait_bound", (cyc - e.icyc) <= BOUND, 1'b1);
            end
            scnt = 0;
        end else if (p == 0 && q0.size() > 0 && cyc - q0[0].icyc > BOUND + 2) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: port 0 no ack after %0d cycles", BOUND + 2);
            void'(q0.pop_front());
        end else if (p == 1 && q1.size() > 0 && cyc - q1[0].icyc > BOUND + 2) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: port 1 no ack after %0d cycles", BOUND + 2);
            void'(q1.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (b.mem_read_o || b.mem_write_o) begin
                if (scnt == 0) begin
                    s_addr = b.mem_addr_o;
                    s_wd   = b.mem_wdata_o;
                    s_we   = b.mem_write_o;
                end else if (b.mem_addr_o !== s_addr) begin
                    chk("addr_hold", b.mem_addr_o, s_addr);
                end
                if (b.mem_read_o && b.mem_write_o) begin
                    chk_b("rd_wr_excl", 1'b1, 1'b0);
                end
                scnt++;
            end
            if (b.m0_ack_o && b.m1_ack_o) chk_b("dual_ack", 1'b1, 1'b0);
            mon_port(0);
            mon_port(1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          nwr;
        int          nrd;
        int          lat;
        int          na;
        int          nack;
        int          aport [0:3];
        int          acyc [0:3];
        bit          pend;

        b1.m0_req_i   = 1'b0;
        b1.m0_we_i    = 1'b0;
        b1.m0_addr_i  = '0;
        b1.m0_wdata_i = '0;
        b1.m1_req_i   = 1'b0;
        b1.m1_we_i    = 1'b0;
        b1.m1_addr_i  = '0;
        b1.m1_wdata_i = '0;
        do_reset();

        // reset state
        chk_b("rst_busy", b.busy_o, 1'b0);
        chk_b("rst_ack0", b.m0_ack_o, 1'b0);
        chk_b("rst_ack1", b.m1_ack_o, 1'b0);
        chk("rst_rd0", b.m0_rdata_o, 32'h0);
        chk("rst_rd1", b.m1_rdata_o, 32'h0);
        chk_b("rst_mrd", b.mem_read_o, 1'b0);
        chk_b("rst_mwr", b.mem_write_o, 1'b0);
        chk("rst_maddr", b.mem_addr_o, 32'h0);

        // m0 read of address 8, exact cycle timing
        set_port(0, 1'b1, 1'b0, 32'd8, 32'h0);
        tick();
        for (int c = 1; c <= 3; c++) begin
            chk_b($sformatf("t1_mrd_c%0d", c), b.mem_read_o, 1'b1);
            chk_b($sformatf("t1_mwr_c%0d", c), b.mem_write_o, 1'b0);
            chk($sformatf("t1_maddr_c%0d", c), b.mem_addr_o, 32'd8);
            chk_b($sformatf("t1_ack_c%0d", c), b.m0_ack_o, 1'b0);
            chk_b($sformatf("t1_busy_c%0d", c), b.busy_o, 1'b1);
            tick();
        end
        chk_b("t1_ack0", b.m0_ack_o, 1'b1);
        chk_b("t1_ack1", b.m1_ack_o, 1'b0);
        chk_b("t1_mrd_done", b.mem_read_o, 1'b0);
        chk("t1_rdata", b.m0_rdata_o, 32'hDEADBEEF);
        set_req(0, 1'b0);
        tick();
        chk_b("t1_ack_off", b.m0_ack_o, 1'b0);
        chk_b("t1_idle", b.busy_o, 1'b0);

        // m1 write then read back
        do_reset();
        xfer(1, 1'b1, 32'd4, 32'h12345678, rd, nwr, nrd, lat);
        chk("t2_wr_cycles", 32'(nwr), 32'd3);
        chk("t2_wr_rd_cycles", 32'(nrd), 32'd0);
        chk("t2_wr_lat", 32'(lat), 32'd4);
        chk("t2_wr_rd1", rd, 32'h0);
        xfer(1, 1'b0, 32'd4, 32'h0, rd, nwr, nrd, lat);
        chk("t2_rd_data", rd, 32'h12345678);
        chk("t2_rd_wr_cycles", 32'(nwr), 32'd0);
        chk("t2_rd_cycles", 32'(nrd), 32'd3);
        chk("t2_m0_rd", b.m0_rdata_o, 32'h0);

        // both masters hold requests: strict alternation
        do_reset();
        set_port(0, 1'b1, 1'b0, 32'd8, 32'h0);
        set_port(1, 1'b1, 1'b0, 32'd4, 32'h0);
        na = 0;
        for (int i = 1; i <= 40 && na < 4; i++) begin
            tick();
            if (b.m0_ack_o || b.m1_ack_o) begin
                aport[na] = b.m1_ack_o ? 1 : 0;
                acyc[na]  = i;
                na++;
            end
        end
        set_req(0, 1'b0);
        set_req(1, 1'b0);
        repeat (3) tick();
        chk("t3_nacks", 32'(na), 32'd4);
        for (int k = 0; k < na; k++) begin
            chk($sformatf("t3_grant%0d", k), 32'(aport[k]), 32'(k % 2));
        end
        for (int k = 1; k < na; k++) begin
            chk($sformatf("t3_gap%0d", k), 32'(acyc[k] - acyc[k-1]), 32'd5);
        end
        chk("t3_first", 32'(acyc[0]), 32'd4);

        // requester changes inputs during ACCESS
        do_reset();
        set_port(0, 1'b1, 1'b1, 32'd8, 32'h11111111);
        tick();
        set_port(0, 1'b1, 1'b1, 32'd12, 32'h22222222);
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("t4_maddr_c%0d", c), b.mem_addr_o, 32'd8);
            chk($sformatf("t4_mwd_c%0d", c), b.mem_wdata_o, 32'h11111111);
            chk_b($sformatf("t4_mwr_c%0d", c), b.mem_write_o, 1'b1);
            tick();
        end
        chk_b("t4_ack", b.m0_ack_o, 1'b1);
        set_req(0, 1'b0);
        tick();

        // reset in the second ACCESS cycle aborts the access
        do_reset();
        set_port(0, 1'b1, 1'b0, 32'd8, 32'h0);
        tick();
        tick();
        chk_b("t5_pre_mrd", b.mem_read_o, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_b("t5_busy", b.busy_o, 1'b0);
        chk_b("t5_mrd", b.mem_read_o, 1'b0);
        chk("t5_maddr", b.mem_addr_o, 32'h0);
        chk_b("t5_ack", b.m0_ack_o, 1'b0);
        set_req(0, 1'b0);
        tick();
        rst_n = 1'b1;
        nack = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (b.m0_ack_o || b.m1_ack_o) nack++;
        end
        chk("t5_no_ack", 32'(nack), 32'd0);
        chk_b("t5_idle", b.busy_o, 1'b0);
        chk("t5_rd0", b.m0_rdata_o, 32'h0);

        // LATENCY = 1 instance
        b1.m0_req_i  = 1'b1;
        b1.m0_addr_i = 32'h20;
        tick();
        chk_b("t6_mrd", b1.mem_read_o, 1'b1);
        chk("t6_maddr", b1.mem_addr_o, 32'h20);
        chk_b("t6_ack_early", b1.m0_ack_o, 1'b0);
        tick();
        chk_b("t6_ack", b1.m0_ack_o, 1'b1);
        chk_b("t6_mrd_off", b1.mem_read_o, 1'b0);
        chk("t6_rdata", b1.m0_rdata_o, 32'hCAFEF00D);
        b1.m0_req_i = 1'b0;
        tick();
        chk_b("t6_ack_off", b1.m0_ack_o, 1'b0);
        chk_b("t6_idle", b1.busy_o, 1'b0);

        // random two-master traffic
        do_reset();
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        last_rd[0] = '0;
        last_rd[1] = '0;
        scnt   = 0;
        mon_en = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < 2; p++) begin
                pend = (p == 0) ? b.m0_req_i : b.m1_req_i;
                if (pend && get_ack(p)) begin
                    if ($urandom_range(0, 1) == 1) issue(p);
                    else set_req(p, 1'b0);
                end else if (!pend && $urandom_range(0, 3) == 0) begin
                    issue(p);
                end
            end
            tick();
        end
        for (int c = 0; c < 60 && (b.m0_req_i || b.m1_req_i); c++) begin
            for (int p = 0; p < 2; p++) begin
                if (get_ack(p)) set_req(p, 1'b0);
            end
            tick();
        end
        repeat (3) tick();
        mon_en = 1'b0;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d requests outstanding, required 0",
                     q0.size(), q1.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
